// File: rtl/sync_fifo_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_if
//
// Purpose:
//   Bundles the producer/consumer side of the synchronous FIFO into one
//   interface. Clock and reset stay as plain ports on the FIFO itself.
//
// Signals:
//   i_wen    write request for the current cycle
//   i_ren    read request for the current cycle
//   i_wdata  write data, sampled when a write is accepted
//   o_valid  one-cycle strobe: o_rdata holds a freshly read word
//   o_full   FIFO holds DEPTH words
//   o_empty  FIFO holds no words
//   o_rdata  registered read data
//
// Modports:
//   master   the user of the FIFO (drives requests, observes status/data)
//   slave    the FIFO itself
// ---------------------------------------------------------------------------
interface sync_fifo_if #(
   parameter int DATA_WIDTH = 8
);

   logic                  i_wen;
   logic                  i_ren;
   logic [DATA_WIDTH-1:0] i_wdata;
   logic                  o_valid;
   logic                  o_full;
   logic                  o_empty;
   logic [DATA_WIDTH-1:0] o_rdata;

   // The user side drives requests and write data, and sees everything else.
   modport master (
      output i_wen,
      output i_ren,
      output i_wdata,
      input  o_valid,
      input  o_full,
      input  o_empty,
      input  o_rdata
   );

   // The FIFO side is the mirror image of the user side.
   modport slave (
      input  i_wen,
      input  i_ren,
      input  i_wdata,
      output o_valid,
      output o_full,
      output o_empty,
      output o_rdata
   );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//
// Purpose:
//   Single-clock first-in/first-out buffer for DATA_WIDTH-bit words. It
//   decouples a producer and a consumer running in the same clock domain.
//   Status is given by full/empty flags, and the read port is registered
//   with a one-cycle data-valid strobe. Writes while full and reads while
//   empty are silently dropped.
//
// Parameters:
//   DATA_WIDTH  width of each stored word in bits
//   DEPTH       number of entries (power of two, at least 2)
//
// Ports:
//   i_clk    rising-edge clock, all state changes on this edge
//   i_reset  synchronous, active-high reset
//   bus      sync_fifo_if slave modport (requests, data, status)
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   sync_fifo_if.slave  bus
);

   // Address width. Pointers carry one extra bit so that "full" and
   // "empty" can be told apart when the address bits are equal.
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [AW:0]           wrPtr_q;
   logic [AW:0]           wrPtr_d;
   logic [AW:0]           rdPtr_q;
   logic [AW:0]           rdPtr_d;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] rdata_d;
   logic                  valid_q;
   logic                  valid_d;

   logic                  empty;
   logic                  full;
   logic                  wrAcc;
   logic                  rdAcc;

   // Status flags come straight from the pointers, so they are exact at
   // every edge. Equal pointers mean empty. Equal addresses but a different
   // wrap bit mean the writer is a whole lap ahead, which is full.
   always_comb begin
      empty = (wrPtr_q == rdPtr_q);
      full  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
              (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   end

   // Requests are accepted against the current flags. A write to an empty
   // FIFO is never forwarded to the read port in the same cycle, so a
   // simultaneous read while empty is simply rejected.
   always_comb begin
      wrAcc = bus.i_wen & ~full;
      rdAcc = bus.i_ren & ~empty;
   end

   // Next-state logic for the pointers and the registered read port.
   // The valid strobe drops by default, and the read data holds its last
   // value unless a read is accepted.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      rdata_d = rdata_q;
      valid_d = 1'b0;
      if (wrAcc) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (rdAcc) begin
         rdPtr_d = rdPtr_q + PTR_ONE;
         rdata_d = mem_q[rdPtr_q[AW-1:0]];
         valid_d = 1'b1;
      end
   end

   // Control state. Reset empties the FIFO by equalising the pointers and
   // clears the read port. It overrides any request in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         rdata_q <= '0;
         valid_q <= 1'b0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
      end
   end

   // Storage array. It is deliberately left out of reset so it can map onto
   // plain RAM. Writes are still blocked during reset, so a request that
   // coincides with reset leaves no trace.
   always_ff @(posedge i_clk) begin
      if (!i_reset && wrAcc) begin
         mem_q[wrPtr_q[AW-1:0]] <= bus.i_wdata;
      end
   end

   // Drive the interface outputs.
   always_comb begin
      bus.o_empty = empty;
      bus.o_full  = full;
      bus.o_valid = valid_q;
      bus.o_rdata = rdata_q;
   end

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//
// Purpose:
//   Self-checking bench for sync_fifo. A queue-based reference model tracks
//   the expected contents and read port. One compare process checks every
//   output on each falling edge. Directed sequences also pin the read-back
//   order and selected flags to hand-computed values.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst;

   sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

   sync_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;

   int          modelQ[$];
   logic        mValid;
   logic [DW-1:0] mRdata;
   bit          modelReady = 1'b0;

   int          readLog[$];
   int          exp[$];

   // Shared comparison. Counts every check and reports any mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Reference model, expressed as occupancy of a queue. Reads pop the
   // oldest word and writes push onto the back. Both decisions use the
   // occupancy seen before this edge.
   always @(posedge clk) begin
      if (rst) begin
         modelQ.delete();
         mValid     = 1'b0;
         mRdata     = '0;
         modelReady = 1'b1;
      end else if (modelReady) begin
         bit canRd;
         bit canWr;
         canRd  = (modelQ.size() != 0);
         canWr  = (modelQ.size() != DEPTH);
         mValid = 1'b0;
         if (bus.i_ren && canRd) begin
            mRdata = modelQ.pop_front()[DW-1:0];
            mValid = 1'b1;
         end
         if (bus.i_wen && canWr) begin
            modelQ.push_back(int'(bus.i_wdata));
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   // Words delivered by the DUT are also logged for the directed order checks.
   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("empty", bus.o_empty, modelQ.size() == 0);
         checkOutput("full",  bus.o_full,  modelQ.size() == DEPTH);
         checkOutput("valid", bus.o_valid, mValid);
         checkOutput("rdata", bus.o_rdata, mRdata);
         if (bus.o_valid === 1'b1) begin
            readLog.push_back(int'(bus.o_rdata));
         end
      end
   end

   // Drive one cycle of requests. Call this at a falling edge; it returns
   // at the next falling edge.
   task automatic applyStimulus(input logic wen, input logic ren, input logic [DW-1:0] d);
      bus.i_wen   = wen;
      bus.i_ren   = ren;
      bus.i_wdata = d;
      @(negedge clk);
   endtask

   task automatic writeRange(input int lo, input int hi);
      for (int v = lo; v <= hi; v++) begin
         applyStimulus(1'b1, 1'b0, v[DW-1:0]);
      end
   endtask

   task automatic readN(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, '0);
      end
   endtask

   task automatic pushRange(input int lo, input int hi);
      for (int v = lo; v <= hi; v++) begin
         exp.push_back(v);
      end
   endtask

   // Compare the logged read-back words with the hand-built expected list.
   task automatic checkLog(input string name);
      #1;
      checkOutput({name, "_count"}, readLog.size(), exp.size());
      for (int i = 0; i < exp.size() && i < readLog.size(); i++) begin
         checkOutput({name, "_word"}, readLog[i], exp[i]);
      end
      readLog.delete();
      exp.delete();
   endtask

   initial begin
      rst         = 1'b1;
      bus.i_wen   = 1'b0;
      bus.i_ren   = 1'b0;
      bus.i_wdata = '0;
      @(negedge clk);

      // 1: reset state
      applyStimulus(1'b0, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      rst = 1'b0;
      #1;
      checkOutput("t1_empty", bus.o_empty, 1);
      checkOutput("t1_full",  bus.o_full,  0);
      checkOutput("t1_valid", bus.o_valid, 0);
      checkOutput("t1_rdata", bus.o_rdata, 0);

      // 2: one-cycle read latency, fill to full, drop extras, flush in order
      applyStimulus(1'b1, 1'b0, 8'd0);
      applyStimulus(1'b0, 1'b1, '0);
      #1;
      checkOutput("t2_valid", bus.o_valid, 1);
      checkOutput("t2_rdata", bus.o_rdata, 0);
      exp.push_back(0);
      checkLog("t2_first");
      writeRange(1, 15);
      writeRange(0, 15);
      #1;
      checkOutput("t2_full", bus.o_full, 1);
      readN(16);
      pushRange(1, 15);
      exp.push_back(0);
      checkLog("t2_flush");

      // 3: underflow reads are dropped, read data holds
      writeRange(1, 16);
      readN(21);
      pushRange(1, 16);
      checkLog("t3_flush");
      checkOutput("t3_valid", bus.o_valid, 0);
      checkOutput("t3_rdata", bus.o_rdata, 16);
      checkOutput("t3_empty", bus.o_empty, 1);

      // 4: full after pointers have wrapped
      writeRange(3, 12);
      readN(5);
      pushRange(3, 7);
      checkLog("t4_part");
      writeRange(100, 124);
      #1;
      checkOutput("t4_full", bus.o_full, 1);
      readN(16);
      pushRange(8, 12);
      pushRange(100, 110);
      checkLog("t4_flush");

      // 5: pointers equal away from zero
      writeRange(4, 8);
      readN(5);
      readN(5);
      pushRange(4, 8);
      checkLog("t5_drain");
      writeRange(1, 16);
      #1;
      checkOutput("t5_full", bus.o_full, 1);
      writeRange(2, 17);
      readN(16);
      pushRange(1, 16);
      checkLog("t5_flush");

      // 6: mid-stream reset, then simultaneous access while empty
      writeRange(50, 56);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 8'h99);
      rst = 1'b0;
      #1;
      checkOutput("t6_empty", bus.o_empty, 1);
      checkOutput("t6_valid", bus.o_valid, 0);
      applyStimulus(1'b0, 1'b1, '0);
      #1;
      checkOutput("t6_rdvalid", bus.o_valid, 0);
      applyStimulus(1'b1, 1'b1, 8'hAB);
      #1;
      checkOutput("t6_wrvalid", bus.o_valid, 0);
      checkOutput("t6_notempty", bus.o_empty, 0);
      applyStimulus(1'b0, 1'b1, '0);
      #1;
      checkOutput("t6_lastvalid", bus.o_valid, 1);
      checkOutput("t6_lastdata", bus.o_rdata, 8'hAB);
      exp.push_back(8'hAB);
      checkLog("t6_log");

      applyStimulus(1'b0, 1'b0, '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
